event_encoder_8to3: RTL and testbench

//  Inverse of the 3-to-8 one-hot decoder: collects events on 8 request lines
//  and emits them one at a time as 3-bit binary codes.

---
 rtl/event_encoder_8to3.sv | 117 +++++++++++
 tb/tb_event_encoder_8to3.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : event_encoder_8to3
// Description : Collects events on 8 request lines into a pending register
//               and emits them one at a time as 3-bit binary codes over a
//               valid/ready handshake, in fixed priority order.
// Revision    : 1.0 - initial release
// ============================================================================
module event_encoder_8to3 #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i,
    input  logic       ready,
    input  logic       ovf_clr,
    output logic [2:0] y,
    output logic       valid,
    output logic [7:0] pending,
    output logic       ovf
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_y;
    logic [2:0] w_y_nxt;
    logic [7:0] r_pend;
    logic [7:0] w_pend_nxt;
    logic       r_ovf;
    logic       w_ovf_nxt;
    logic       w_hs;
    logic [7:0] w_yhot;
    logic [7:0] w_clr;
    logic [7:0] w_rem;
    logic       w_merge;

    // Priority pick of one index out of a vector; direction set by HIGH_FIRST.
    // The loop lets the last set bit visited win.
    function automatic logic [2:0] f_sel(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int b = 0; b < 8; b++) begin
                if (v[b]) idx = 3'(b);
            end
        end else begin
            for (int b = 7; b >= 0; b--) begin
                if (v[b]) idx = 3'(b);
            end
        end
        return idx;
    endfunction

    assign w_hs    = valid && ready;
    assign w_yhot  = 8'd1 << r_y;
    assign w_clr   = w_hs ? w_yhot : 8'd0;
    // Set wins over clear, so a re-raise of the served bit stays pending.
    assign w_pend_nxt = (r_pend & ~w_clr) | i;
    // Remaining work after the current code is accepted (new arrivals excluded).
    assign w_rem   = r_pend & ~w_yhot;
    // A new event landing on a bit still pending (and not just served) merges.
    assign w_merge = |(i & r_pend & ~w_clr);
    assign w_ovf_nxt = w_merge ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);

    // Next-state and code selection; y only changes when a new code is loaded.
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        case (r_state)
            S_IDLE: begin
                if (r_pend != 8'd0) begin
                    w_y_nxt     = f_sel(r_pend);
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (w_hs) begin
                    if (w_rem != 8'd0) begin
                        w_y_nxt = f_sel(w_rem);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, code, pending vector and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_y     <= 3'd0;
            r_pend  <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign y       = r_y;
    assign valid   = (r_state == S_PRESENT);
    assign pending = r_pend;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_encoder_8to3
// Description : Self-checking bench for event_encoder_8to3. Two instances
//               (high-first and low-first) share stimulus and are compared
//               each cycle against a behavioural model, plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] yh, yl;
    logic       vh, vl;
    logic [7:0] ph, pl;
    logic       oh, ol;

    int vectors = 0;
    int miscompares = 0;

    // Reference state, index 0 = high-first, index 1 = low-first.
    logic [7:0] m_pend  [2];
    logic [2:0] m_y     [2];
    logic       m_valid [2];
    logic       m_ovf   [2];

    always #5 clk = ~clk;

    event_encoder_8to3 #(.HIGH_FIRST(1)) dut_h (
        .clk(clk), .rst(rst), .i(i), .ready(ready), .ovf_clr(ovf_clr),
        .y(yh), .valid(vh), .pending(ph), .ovf(oh)
    );

    event_encoder_8to3 #(.HIGH_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .i(i), .ready(ready), .ovf_clr(ovf_clr),
        .y(yl), .valid(vl), .pending(pl), .ovf(ol)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input bit hf);
        if (hf) begin
            for (int b = 7; b >= 0; b--) if (v[b]) return b;
        end else begin
            for (int b = 0; b < 8; b++) if (v[b]) return b;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit         hf;
            bit         hs;
            bit         mrg;
            logic [7:0] nx;
            logic [7:0] rem;
            hf = (k == 0);
            if (rst) begin
                m_pend[k] = 8'd0; m_y[k] = 3'd0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
            end else begin
                hs  = m_valid[k] && ready;
                nx  = m_pend[k];
                mrg = 1'b0;
                if (hs) nx[m_y[k]] = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    if (i[b]) begin
                        if (nx[b]) mrg = 1'b1;
                        nx[b] = 1'b1;
                    end
                end
                if (!m_valid[k]) begin
                    if (m_pend[k] != 8'd0) begin
                        m_y[k]     = 3'(pick(m_pend[k], hf));
                        m_valid[k] = 1'b1;
                    end
                end else if (hs) begin
                    rem = m_pend[k];
                    rem[m_y[k]] = 1'b0;
                    if (rem != 8'd0) m_y[k] = 3'(pick(rem, hf));
                    else             m_valid[k] = 1'b0;
                end
                if (mrg)          m_ovf[k] = 1'b1;
                else if (ovf_clr) m_ovf[k] = 1'b0;
                m_pend[k] = nx;
            end
        end
    endtask

    task automatic cmp_all();
        chk("model_y_h",   8'(yh), 8'(m_y[0]));
        chk("model_v_h",   8'(vh), 8'(m_valid[0]));
        chk("model_p_h",   ph,     m_pend[0]);
        chk("model_o_h",   8'(oh), 8'(m_ovf[0]));
        chk("model_y_l",   8'(yl), 8'(m_y[1]));
        chk("model_v_l",   8'(vl), 8'(m_valid[1]));
        chk("model_p_l",   pl,     m_pend[1]);
        chk("model_o_l",   8'(ol), 8'(m_ovf[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        rst = 1'b1; i = 8'hFF; ready = 1'b0; ovf_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 8'd0; m_y[k] = 3'd0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end

        // Reset with every request line high.
        tick(); tick();
        chk("rst_pend", ph, 8'h00);
        chk("rst_valid", 8'(vh), 8'h00);
        chk("rst_y", 8'(yh), 8'h00);
        chk("rst_ovf", 8'(oh), 8'h00);
        rst = 1'b0; i = 8'h00;
        tick();

        // Single event, two-cycle latency.
        i = 8'h20; ready = 1'b1; tick();
        i = 8'h00;
        chk("single_lat_v", 8'(vh), 8'h00);
        chk("single_lat_p", ph, 8'h20);
        tick();
        chk("single_v", 8'(vh), 8'h01);
        chk("single_y", 8'(yh), 8'h05);
        tick();
        chk("single_drop", 8'(vh), 8'h00);
        chk("single_pend", ph, 8'h00);

        // Burst in both priority orders.
        i = 8'h93; tick();
        i = 8'h00;
        tick(); chk("burst_h0", 8'(yh), 8'd7); chk("burst_l0", 8'(yl), 8'd0);
        tick(); chk("burst_h1", 8'(yh), 8'd4); chk("burst_l1", 8'(yl), 8'd1);
        tick(); chk("burst_h2", 8'(yh), 8'd1); chk("burst_l2", 8'(yl), 8'd4);
        tick(); chk("burst_h3", 8'(yh), 8'd0); chk("burst_l3", 8'(yl), 8'd7);
        tick(); chk("burst_end_h", 8'(vh), 8'h00); chk("burst_end_l", 8'(vl), 8'h00);

        // Backpressure: code held stable, no re-prioritisation.
        ready = 1'b0; i = 8'h0C; tick();
        i = 8'h00;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_y", 8'(yh), 8'd3);
            chk("bp_v", 8'(vh), 8'h01);
        end
        i = 8'h80; tick();
        i = 8'h00; tick();
        chk("bp_hold_y", 8'(yh), 8'd3);
        chk("bp_hold_p", ph, 8'h8C);
        ready = 1'b1;
        tick(); chk("bp_seq1", 8'(yh), 8'd7);
        tick(); chk("bp_seq2", 8'(yh), 8'd2);
        tick(); chk("bp_done", 8'(vh), 8'h00);

        // Overflow by merge, clear priority.
        ready = 1'b0; i = 8'h02; tick();
        i = 8'h00; tick();
        i = 8'h02; tick();
        i = 8'h00;
        chk("ovf_set", 8'(oh), 8'h01);
        chk("ovf_pend", ph, 8'h02);
        i = 8'h02; ovf_clr = 1'b1; tick();
        chk("ovf_set_wins", 8'(oh), 8'h01);
        i = 8'h00; tick();
        chk("ovf_clr", 8'(oh), 8'h00);
        ovf_clr = 1'b0; ready = 1'b1; tick();
        chk("ovf_one_code", 8'(vh), 8'h00);
        chk("ovf_pend_zero", ph, 8'h00);

        // Same-bit re-raise during its own handshake.
        ready = 1'b0; i = 8'h10; tick();
        i = 8'h00; tick();
        chk("reraise_y", 8'(yh), 8'd4);
        ready = 1'b1; i = 8'h10; tick();
        i = 8'h00;
        chk("reraise_ovf", 8'(oh), 8'h00);
        chk("reraise_pend", ph, 8'h10);
        tick();
        chk("reraise_again_v", 8'(vh), 8'h01);
        chk("reraise_again_y", 8'(yh), 8'd4);
        tick();
        chk("reraise_done", 8'(vh), 8'h00);

        // Reset in the middle of a burst drops everything.
        i = 8'hFF; tick();
        i = 8'h00; tick(); tick();
        rst = 1'b1; tick();
        chk("midrst_pend", ph, 8'h00);
        chk("midrst_valid", 8'(vh), 8'h00);
        chk("midrst_y", 8'(yh), 8'h00);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            ready   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
